// File: rtl/pipe_gap_scheduler.sv
// Pipe spawn scheduler: LFSR rejection-sampled gap heights offered over valid/ready.
// Define RNG_FREERUN_EN to step the LFSR every cycle instead of only while drawing.
module pipe_gap_scheduler #(
  parameter int SPAWN_FRAMES = 90,
  parameter int GAP_MIN      = 40,
  parameter int GAP_MAX      = 160,
  parameter int MAX_TRIES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic        seed_load,
  input  logic [20:0] seed_in,
  output logic [7:0]  gap_y,
  output logic        gap_valid,
  input  logic        gap_ready,
  output logic        spawn_overrun,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_OFFER = 2'd3;

  localparam int CW = $clog2(SPAWN_FRAMES + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPAWN_FRAMES - 1);
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
  localparam logic [7:0] G_MIN = 8'(GAP_MIN);
  localparam logic [7:0] G_MAX = 8'(GAP_MAX);
  localparam logic [20:0] SEED_DEF = 21'h1FFFFF;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tries, tries_n;
  logic          pending, pending_n;
  logic [20:0]   lfsr, lfsr_n;
  logic [7:0]    gap_y_n;
  logic          gap_valid_n;
  logic          overrun_n;
  logic          expire;
  logic          hs;
  logic          lfsr_step;
  logic [7:0]    cand;

  assign cand   = lfsr[7:0];
  assign hs     = gap_valid && gap_ready;
  assign busy   = (state == S_DRAW) || (state == S_OFFER);
  assign expire = enable && (state != S_IDLE) && frame_tick
                  && (cnt == CNT_LAST);

`ifdef RNG_FREERUN_EN
  assign lfsr_step = 1'b1;
`else
  assign lfsr_step = enable && (state == S_DRAW);
`endif

  always_comb begin
    lfsr_n = lfsr;
    if (seed_load)
      lfsr_n = (seed_in == '0) ? SEED_DEF : seed_in;
    else if (lfsr_step)
      lfsr_n = {lfsr[19:0], lfsr[20] ^ lfsr[17]};
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tries_n     = tries;
    pending_n   = pending;
    gap_y_n     = gap_y;
    gap_valid_n = gap_valid;
    overrun_n   = 1'b0;
    if (!enable) begin
      state_n     = S_IDLE;
      cnt_n       = '0;
      tries_n     = '0;
      pending_n   = 1'b0;
      gap_valid_n = 1'b0;
    end else begin
      if (state != S_IDLE && frame_tick)
        cnt_n = expire ? '0 : cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (expire) begin
            state_n = S_DRAW;
            tries_n = '0;
          end
        end
        S_DRAW: begin
          if (cand >= G_MIN && cand <= G_MAX) begin
            gap_y_n     = cand;
            gap_valid_n = 1'b1;
            state_n     = S_OFFER;
          end else if (tries == TRY_LAST) begin
            gap_y_n     = (cand > G_MAX) ? G_MAX : G_MIN;
            gap_valid_n = 1'b1;
            state_n     = S_OFFER;
          end else begin
            tries_n = tries + 1'b1;
          end
          if (expire) begin
            overrun_n = pending;
            pending_n = 1'b1;
          end
        end
        S_OFFER: begin
          if (hs) begin
            gap_valid_n = 1'b0;
            // a same-cycle expiry takes the slot the handshake frees
            if (pending || expire) begin
              state_n   = S_DRAW;
              tries_n   = '0;
              pending_n = pending && expire;
            end else begin
              state_n = S_WAIT;
            end
          end else if (expire) begin
            overrun_n = pending;
            pending_n = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      tries         <= '0;
      pending       <= 1'b0;
      lfsr          <= SEED_DEF;
      gap_y         <= '0;
      gap_valid     <= 1'b0;
      spawn_overrun <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      tries         <= tries_n;
      pending       <= pending_n;
      lfsr          <= lfsr_n;
      gap_y         <= gap_y_n;
      gap_valid     <= gap_valid_n;
      spawn_overrun <= overrun_n;
    end
  end

endmodule
